// File: rtl/facedet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : facedet_pkg
// Description : Shared widths and state encoding for the face-detection
//               front end (integral image generator and its row buffer).
// Revision    : 1.0 - initial release
// ============================================================================
package facedet_pkg;

    localparam int PIX_W         = 8;
    localparam int SUM_W         = 32;
    localparam int ADDR_W        = 17;
    localparam int MAX_WIDTH     = 512;
    localparam int MAX_IMG_WORDS = 100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ii_state_t;

endpackage
`default_nettype wire

// File: rtl/ii_row_buf.sv
`default_nettype none
// ============================================================================
// Module      : ii_row_buf
// Description : One-row store of integral values from the previous image
//               row. Combinational read and synchronous write share a single
//               index, so a same-cycle read at the write index returns the old
//               word. Kept as a separate block so it can become a RAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
module ii_row_buf #(
    parameter int DEPTH  = facedet_pkg::MAX_WIDTH,
    parameter int DATA_W = facedet_pkg::SUM_W,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the freshly computed integral value back into its column slot
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/integral_image_gen.sv
`default_nettype none
// ============================================================================
// Module      : integral_image_gen
// Description : Streams raster-order pixels of one tile and emits its
//               summed-area table as (address, value) writes into the
//               detector's image memory. One word per cycle, latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module integral_image_gen
    import facedet_pkg::*;
#(
    parameter int PIX_W     = facedet_pkg::PIX_W,
    parameter int SUM_W     = facedet_pkg::SUM_W,
    parameter int MAX_WIDTH = facedet_pkg::MAX_WIDTH,
    parameter int ADDR_W    = facedet_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              ii_valid,
    output logic [SUM_W-1:0]  ii_data,
    output logic [ADDR_W-1:0] ii_addr,
    input  logic              ii_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                c_idx_w     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [15:0]       c_max_width = 16'(MAX_WIDTH);
    localparam logic [31:0]       c_max_words = 32'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    ii_state_t         r_state;
    logic [15:0]       r_width;
    logic [15:0]       r_height;
    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic [SUM_W-1:0]  r_row_acc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ii_valid;
    logic [SUM_W-1:0]  r_ii_data;
    logic [ADDR_W-1:0] r_ii_addr;
    logic              r_done;
    logic              r_err;

    logic              w_pix_ready;
    logic              w_accept;
    logic              w_last_col;
    logic              w_last_pix;
    logic [31:0]       w_area;
    logic              w_geom_bad;
    logic [SUM_W-1:0]  w_pix_ext;
    logic [SUM_W-1:0]  w_row_acc_next;
    logic [SUM_W-1:0]  w_above;
    logic [SUM_W-1:0]  w_ii;

    // The output register is the only buffering: take a pixel only when the
    // word it produces has somewhere to go this cycle.
    assign w_pix_ready = (r_state == RUN) && (!r_ii_valid || ii_ready);
    assign w_accept    = pix_valid && w_pix_ready;

    assign w_last_col  = (r_x == r_width - 16'd1);
    assign w_last_pix  = w_last_col && (r_y == r_height - 16'd1);

    // Both factors are below 2^16, so the 32-bit product cannot overflow
    assign w_area      = 32'(width) * 32'(height);
    assign w_geom_bad  = (width == 16'd0) || (height == 16'd0) ||
                         (width > c_max_width) || (w_area > c_max_words);

    // Running row sum plus the column total of all rows above
    assign w_pix_ext      = {{(SUM_W-PIX_W){1'b0}}, pix_data};
    assign w_row_acc_next = ((r_x == 16'd0) ? '0 : r_row_acc) + w_pix_ext;
    assign w_ii           = w_row_acc_next + ((r_y == 16'd0) ? '0 : w_above);

    ii_row_buf #(
        .DEPTH  (MAX_WIDTH),
        .DATA_W (SUM_W),
        .IDX_W  (c_idx_w)
    ) u_row_buf (
        .clk   (clk),
        .we    (w_accept),
        .idx   (r_x[c_idx_w-1:0]),
        .wdata (w_ii),
        .rdata (w_above)
    );

    // Frame control: geometry check, raster counters, drain and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_width   <= 16'd0;
            r_height  <= 16'd0;
            r_x       <= 16'd0;
            r_y       <= 16'd0;
            r_row_acc <= '0;
            r_addr    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_geom_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_width   <= width;
                            r_height  <= height;
                            r_x       <= 16'd0;
                            r_y       <= 16'd0;
                            r_row_acc <= '0;
                            r_addr    <= '0;
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_row_acc <= w_row_acc_next;
                        r_addr    <= r_addr + c_addr_one;
                        if (w_last_col) begin
                            r_x <= 16'd0;
                            r_y <= r_y + 16'd1;
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                        if (w_last_pix) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // The last word is always pending here; wait for it to leave
                    if (r_ii_valid && ii_ready) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output word register: load on accept, hold while stalled, clear once taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ii_valid <= 1'b0;
            r_ii_data  <= '0;
            r_ii_addr  <= '0;
        end else if (w_accept) begin
            r_ii_valid <= 1'b1;
            r_ii_data  <= w_ii;
            r_ii_addr  <= r_addr;
        end else if (ii_ready) begin
            r_ii_valid <= 1'b0;
        end
    end

    assign pix_ready = w_pix_ready;
    assign ii_valid  = r_ii_valid;
    assign ii_data   = r_ii_data;
    assign ii_addr   = r_ii_addr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
